// File: rtl/sw_input_conditioner_pkg.sv
// Shared constants and types for the switch input conditioner.
// Switch channel indices and 50 MHz defaults live here so every consumer agrees on them.
package sw_input_conditioner_pkg;

    localparam int SW_RESET = 0;
    localparam int SW_ENA   = 1;
    localparam int SW_SENS1 = 2;
    localparam int SW_SENS2 = 3;
    localparam int SW_PEAK  = 4;
    localparam int SW_PEAK1 = 5;

    // 20 ms debounce window and 0.5 s tick period at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_TICK_DIV        = 25_000_000;

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_input_conditioner_if.sv
// Switch conditioner bus: raw switches and tick enable in, clean levels, strobes and tick out.
interface sw_input_conditioner_if #(
    parameter int N_SW = 6
);
    logic [N_SW-1:0] sw_raw;
    logic            tick_en;
    logic [N_SW-1:0] sw_db;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            tick;

    modport master (
        output sw_raw, tick_en,
        input  sw_db, sw_rise, sw_fall, tick
    );

    modport slave (
        input  sw_raw, tick_en,
        output sw_db, sw_rise, sw_fall, tick
    );
endinterface

// File: rtl/sw_input_conditioner_debounce_ch.sv
// One switch channel: synchroniser chain, debounce counter, two-state level FSM and
// registered rise/fall strobes that fire in the same cycle the clean level changes.
module sw_debounce_ch
    import sw_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_e              r_state;
    db_state_e              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Counter clears whenever the synchronised input agrees with the level, so any bounce restarts qualification
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_HI;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_LO;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = STABLE_LO;
        endcase
    end

    assign o_db   = (r_state == STABLE_HI);
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/sw_input_conditioner.sv
// Switch front end: N_SW independent debounce channels plus a gated tick divider that
// replaces the free-running divided clock with a one-cycle enable in the clk domain.
module sw_input_conditioner
    import sw_input_conditioner_pkg::*;
#(
    parameter int N_SW            = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int TICK_W          = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    sw_input_conditioner_if.slave  bus
);
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
        $fatal(1, "CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (TICK_DIV < 2 || (64'd1 << TICK_W) < 64'(TICK_DIV)) begin : g_bad_tick
        $fatal(1, "TICK_W too narrow for TICK_DIV, or TICK_DIV below 2");
    end

    logic [N_SW-1:0] w_db;
    logic [N_SW-1:0] w_rise;
    logic [N_SW-1:0] w_fall;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
        sw_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (bus.sw_raw[gi]),
            .o_db   (w_db[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
        );
    end

    assign bus.sw_db   = w_db;
    assign bus.sw_rise = w_rise;
    assign bus.sw_fall = w_fall;

    localparam logic [TICK_W-1:0] TCNT_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_tcnt;
    logic              r_tick;

    // Divider freezes while disabled, so pauses stretch the period instead of losing phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else if (bus.tick_en) begin
            if (r_tcnt == TCNT_LAST) begin
                r_tcnt <= '0;
                r_tick <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + TICK_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign bus.tick = r_tick;
endmodule
